ssd_scan_driver: RTL and testbench

- Parametrised multi-digit seven-segment scan driver; next generation of the fixed 4-digit, 12-bit `ssd` output path on the CPU board top level.
- The CPU writes a packed hex value through a one-cycle strobe.
- The block double-buffers the value, time-multiplexes NUM_DIGITS digits, inserts an anti-ghosting blank interval per digit slot, and drives a registered `{anodes, segments}` bus.

---
 rtl/ssd_scan_driver.sv | 152 +++++++++++++++
 tb/tb_ssd_scan_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// Multi-digit seven-segment scan driver: double-buffered hex value, per-slot blanking, registered
// {anodes, segments} bus. Define SSD_LEADING_ZERO_BLANK_EN to suppress leading-zero digits.
module ssd_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIV          = 100000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      wr_en,
    input  logic [4*NUM_DIGITS-1:0]   wr_data,
    input  logic [NUM_DIGITS-1:0]     wr_dp,
    output logic                      frame_start,
    output logic [NUM_DIGITS+7:0]     ssd
);

    localparam int unsigned SlotW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned SsdW  = NUM_DIGITS + 8;

    localparam logic [SlotW-1:0] SlotLast  = SlotW'(DIV - 1);
    // Only compared while in StBlank, which is unreachable when BLANK_CYCLES is 0.
    localparam logic [SlotW-1:0] BlankLast = SlotW'(BLANK_CYCLES - 1);
    localparam logic [IdxW-1:0]  IdxLast   = IdxW'(NUM_DIGITS - 1);
    localparam logic [SsdW-1:0]  SsdIdle   = {SsdW{ACTIVE_LOW}};

    typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

    state_e                  state_q, state_d, first_slot;
    logic [SlotW-1:0]        slot_cnt_q, slot_cnt_d;
    logic [IdxW-1:0]         digit_idx_q, digit_idx_d;
    logic                    frame_boundary;
    logic [4*NUM_DIGITS-1:0] pend_data_q, shadow_data_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, shadow_dp_q;
    logic [NUM_DIGITS-1:0]   lz_mask, anode_onehot;
    logic [3:0]              cur_nib;
    logic [7:0]              cur_seg;
    logic [SsdW-1:0]         ssd_raw, ssd_q;
    logic                    frame_start_d, frame_start_q;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        unique case (nib)
            4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
        endcase
    endfunction

    assign first_slot = (BLANK_CYCLES == 0) ? StDrive : StBlank;

    always_comb begin
        state_d        = state_q;
        slot_cnt_d     = slot_cnt_q;
        digit_idx_d    = digit_idx_q;
        frame_boundary = 1'b0;
        if (!en) begin
            state_d     = StIdle;
            slot_cnt_d  = '0;
            digit_idx_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d        = first_slot;
                    slot_cnt_d     = '0;
                    digit_idx_d    = '0;
                    frame_boundary = 1'b1;
                end
                StBlank, StDrive: begin
                    if (slot_cnt_q == SlotLast) begin
                        slot_cnt_d = '0;
                        state_d    = first_slot;
                        if (digit_idx_q == IdxLast) begin
                            digit_idx_d    = '0;
                            frame_boundary = 1'b1;
                        end else begin
                            digit_idx_d = digit_idx_q + 1'b1;
                        end
                    end else begin
                        slot_cnt_d = slot_cnt_q + 1'b1;
                        if (state_q == StBlank && slot_cnt_q == BlankLast) state_d = StDrive;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic lz_seen;
    // A digit is suppressed when it and every digit above it hold zero; digit 0 always shows.
    always_comb begin
        lz_mask = '0;
        lz_seen = 1'b0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            lz_seen    = lz_seen | (shadow_data_q[4*i +: 4] != 4'h0);
            lz_mask[i] = !lz_seen;
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign cur_nib      = shadow_data_q[{digit_idx_q, 2'b00} +: 4];
    assign anode_onehot = NUM_DIGITS'(1) << digit_idx_q;

    always_comb begin
        cur_seg = {shadow_dp_q[digit_idx_q], seg7(cur_nib)};
        if (lz_mask[digit_idx_q]) cur_seg[6:0] = 7'h00;
        unique case (state_q)
            StBlank: ssd_raw = {{NUM_DIGITS{1'b0}}, cur_seg};
            StDrive: ssd_raw = {anode_onehot, cur_seg};
            default: ssd_raw = '0;
        endcase
        frame_start_d = (state_q != StIdle) && (slot_cnt_q == '0) && (digit_idx_q == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            slot_cnt_q    <= '0;
            digit_idx_q   <= '0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            ssd_q         <= SsdIdle;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            ssd_q         <= ssd_raw ^ SsdIdle;
            frame_start_q <= frame_start_d;
            if (wr_en) begin
                pend_data_q <= wr_data;
                pend_dp_q   <= wr_dp;
            end
            // A write landing on the boundary bypasses pending so no stale frame is shown.
            if (frame_boundary) begin
                shadow_data_q <= wr_en ? wr_data : pend_data_q;
                shadow_dp_q   <= wr_en ? wr_dp : pend_dp_q;
            end
        end
    end

    assign ssd         = ssd_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver: a 4-digit low-true instance and a 1-digit high-true
// instance sharing clock and reset.
module tb_ssd_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        en_a = 1'b0, wr_en_a = 1'b0;
    logic [15:0] wr_data_a = '0;
    logic [3:0]  wr_dp_a = '0;
    logic        frame_start_a;
    logic [11:0] ssd_a;

    logic        en_b = 1'b0, wr_en_b = 1'b0;
    logic [3:0]  wr_data_b = '0;
    logic [0:0]  wr_dp_b = '0;
    logic        frame_start_b;
    logic [8:0]  ssd_b;

    int n_cmp = 0;
    int n_fail = 0;

`ifdef SSD_LEADING_ZERO_BLANK_EN
    localparam logic [31:0] FZero = 32'hFFFF_FFC0;
    localparam logic [31:0] F0050 = 32'hFFFF_92C0;
`else
    localparam logic [31:0] FZero = 32'hC0C0_C0C0;
    localparam logic [31:0] F0050 = 32'hC0C0_92C0;
`endif
    // Packed {digit3, digit2, digit1, digit0} low-true segment bytes.
    localparam logic [31:0] F1234 = 32'hF9A4_B019;
    localparam logic [31:0] FABCD = 32'h8883_C6A1;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .NUM_DIGITS(4), .DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)
    ) u_dut_a (
        .clk(clk), .reset(reset), .en(en_a), .wr_en(wr_en_a), .wr_data(wr_data_a),
        .wr_dp(wr_dp_a), .frame_start(frame_start_a), .ssd(ssd_a)
    );

    ssd_scan_driver #(
        .NUM_DIGITS(1), .DIV(4), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b0)
    ) u_dut_b (
        .clk(clk), .reset(reset), .en(en_b), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .wr_dp(wr_dp_b), .frame_start(frame_start_b), .ssd(ssd_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks display cycles k0..k1-1 of a frame (cycle 0 = frame_start), optionally writing at wr_at.
    task automatic run_frame(input logic [31:0] segs, input int k0, input int k1, input int wr_at,
                             input logic [15:0] wd, input logic [3:0] wdp, input string tag);
        for (int k = k0; k < k1; k++) begin
            int n = k / 8;
            int c = k % 8;
            logic [3:0]  exp_an = (c < 2) ? 4'hF : ~(4'b0001 << n);
            logic [11:0] exp_ssd = {exp_an, segs[8*n +: 8]};
            logic        exp_fs = (k == 0);
            n_cmp++;
            if (ssd_a !== exp_ssd) begin
                n_fail++;
                $display("FAIL %s k=%0d ssd: got %h want %h", tag, k, ssd_a, exp_ssd);
            end
            n_cmp++;
            if (frame_start_a !== exp_fs) begin
                n_fail++;
                $display("FAIL %s k=%0d frame_start: got %b want %b", tag, k, frame_start_a, exp_fs);
            end
            if (k == wr_at) begin
                wr_en_a = 1'b1; wr_data_a = wd; wr_dp_a = wdp;
            end else begin
                wr_en_a = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_reset();
        step(); step();
        n_cmp++;
        if (ssd_a !== 12'hFFF || frame_start_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: got ssd=%h fs=%b want FFF 0", ssd_a, frame_start_a);
        end
        n_cmp++;
        if (ssd_b !== 9'h000 || frame_start_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: got ssd=%h fs=%b want 000 0", ssd_b, frame_start_b);
        end
        reset = 1'b1;
        en_a = 1'b1;
        for (int i = 0; i < 6; i++) step();
        n_cmp++;
        if (ssd_a !== 12'hEC0) begin
            n_fail++;
            $display("FAIL pre_reset_drive: got %h want EC0", ssd_a);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (ssd_a !== 12'hFFF) begin
            n_fail++;
            $display("FAIL async_reset: got %h want FFF", ssd_a);
        end
        en_a = 1'b0;
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (ssd_a !== 12'hFFF || frame_start_a !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_reset c=%0d: got ssd=%h fs=%b want FFF 0", i, ssd_a,
                         frame_start_a);
            end
        end
    endtask

    task automatic test_scan();
        en_a = 1'b1;
        step();
        n_cmp++;
        if (ssd_a !== 12'hFFF || frame_start_a !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_start: got ssd=%h fs=%b want FFF 0", ssd_a, frame_start_a);
        end
        step();
        run_frame(FZero, 0, 32, 0, 16'h1234, 4'b0001, "frame_zero");
        run_frame(F1234, 0, 32, -1, 16'h0, 4'h0, "frame_1234");
    endtask

    task automatic test_boundary_write();
        run_frame(F1234, 0, 32, 30, 16'hABCD, 4'b0000, "frame_bypass_old");
        run_frame(FABCD, 0, 32, -1, 16'h0, 4'h0, "frame_abcd");
    endtask

    task automatic test_en_drop();
        run_frame(FABCD, 0, 19, -1, 16'h0, 4'h0, "frame_pre_drop");
        en_a = 1'b0;
        step();
        n_cmp++;
        if (ssd_a !== 12'hB83) begin
            n_fail++;
            $display("FAIL drop_lag: got %h want B83", ssd_a);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (ssd_a !== 12'hFFF || frame_start_a !== 1'b0) begin
                n_fail++;
                $display("FAIL drop_dark c=%0d: got ssd=%h fs=%b want FFF 0", i, ssd_a,
                         frame_start_a);
            end
        end
        en_a = 1'b1;
        step();
        n_cmp++;
        if (ssd_a !== 12'hFFF || frame_start_a !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_lag: got ssd=%h fs=%b want FFF 0", ssd_a, frame_start_a);
        end
        step();
        run_frame(FABCD, 0, 32, -1, 16'h0, 4'h0, "frame_restart");
    endtask

    task automatic test_back_to_back();
        wr_en_a = 1'b1; wr_data_a = 16'h9999; wr_dp_a = 4'hF;
        step();
        wr_data_a = 16'h0050; wr_dp_a = 4'h0;
        step();
        wr_en_a = 1'b0;
        run_frame(FABCD, 2, 32, -1, 16'h0, 4'h0, "frame_b2b_old");
        run_frame(F0050, 0, 32, -1, 16'h0, 4'h0, "frame_0050");
    endtask

    task automatic test_single_digit();
        wr_en_b = 1'b1; wr_data_b = 4'h8; wr_dp_b = 1'b0;
        step();
        wr_en_b = 1'b0;
        n_cmp++;
        if (ssd_b !== 9'h000) begin
            n_fail++;
            $display("FAIL single_idle_write: got %h want 000", ssd_b);
        end
        en_b = 1'b1;
        step();
        n_cmp++;
        if (ssd_b !== 9'h000 || frame_start_b !== 1'b0) begin
            n_fail++;
            $display("FAIL single_start: got ssd=%h fs=%b want 000 0", ssd_b, frame_start_b);
        end
        step();
        for (int k = 0; k < 12; k++) begin
            logic exp_fs = (k % 4 == 0);
            n_cmp++;
            if (ssd_b !== 9'h17F || frame_start_b !== exp_fs) begin
                n_fail++;
                $display("FAIL single_scan k=%0d: got ssd=%h fs=%b want 17F %b", k, ssd_b,
                         frame_start_b, exp_fs);
            end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan();
        test_boundary_write();
        test_en_drop();
        test_back_to_back();
        test_single_digit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
